u_pcoin: RTL and testbench
==========================

# u_pcoin

SHA-256 hashing block for the uPcoin FPGA miner. An SPI-style serial port shifts in one or more 512-bit pre-padded message blocks. A round-per-cycle compression core hashes each block and chains the state across blocks. The final 256-bit digest is shifted back out on the same serial port. It sits between the external microcontroller (SPI master) and the on-chip hashing datapath.

## Interface
- Parameters: none (SHA-256 constants and IV are fixed).
- clk  in  1  system clock; all core logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  serial clock from the master. It directly clocks the serial shift registers: input on rising edge, output on falling edge. Its high time may be shorter than one clk period.
- sdi  in  1  serial data in, MSB first.
- sdo  out  1  serial data out, digest MSB first.
- block_load  in  1  high while a 512-bit block is being shifted in; falling edge starts compression of that block.
- message_load  in  1  high for the whole multi-block message; low means no more blocks follow.
- load  in  1  high means a new message begins; holds the chaining state at the SHA-256 IV.
- done  out  1  digest valid and ready to shift out.

## Operation
- Input shift register (512 b): on each sck rising edge while block_load=1, shift left and insert sdi at bit 0. After 512 edges, bit 511 is the first bit sent.
- The core synchronizes block_load, message_load and load into clk with 2 flops. Input register contents are stable, and sampled by the core, only after block_load is seen low.
- Chaining state H0..H7: forced to the standard IV (6a09e667 … 5be0cd19) while load=1 and at reset.
- FSM states:
  - IDLE: on synchronized block_load falling edge, latch the block into W[0..15] and copy H to a..h, then go to ROUND.
  - ROUND: t = 0..63, one round per clk, using the on-the-fly message schedule (W ring of 16 words, σ0/σ1) and K[t]. All adds are mod 2^32. After t=63, go to UPDATE.
  - UPDATE: H_i += working var (mod 2^32), then go to IDLE.
- Further blocks chain from the updated H. The master starts the next block only after the current one finishes; the core ignores a block_load falling edge outside IDLE.
- Done:
  - done is set when in IDLE with synchronized message_load=0 and at least one block hashed since load. At the same time, H0..H7 (H0 MSBs) are copied into a 256-bit output register.
  - done clears when message_load or load returns high, or on reset.
- Output shifting: sdo = output register bit 255. While done=1, each sck falling edge shifts the register left by one. The master samples sdo while sck is high: the first high phase yields bit 255, and 256 pulses yield the full digest.
- sck edges while block_load=0 and done=0 change nothing.
- Reset mid-operation: return to IDLE, H=IV, done=0, output register=0; input register contents are don't-care.

## Timing
- Reset values: done=0, sdo=0, FSM=IDLE.
- Block latency: ≤ 70 clk from block_load falling at the pin to UPDATE complete (2–3 sync cycles + 1 latch + 64 rounds + 1 update).
- done rises ≤ 3 clk after message_load falls, provided the core is in IDLE.
- Master timing guarantees:
  - block_load stays low ≥ 100 clk between blocks.
  - sdi is set up ≥ 1 clk-phase before each sck rising edge.
  - Reading starts only after done=1.
- Consecutive sck pulses may be 1 clk period apart.

## Test plan
- Single block: load=1, shift 512'h6162638000…0018; drop load and block_load, then message_load; wait for done; clock out 256 bits → ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Two blocks: shift 1024 padded bits of "abcdefghbcdefghi…nopqrstu" (896-bit message) as two block_load frames, with block_load low ~1000 clk between them; then message_load=0 → cf5b16a778af8380036ce59e7b0492370b249b11e8f07a51afac45037afee9d1.
- Chaining reset: after the two-block test, raise load and message_load, then rerun the single-block "abc" → ba7816bf…15ad (IV correctly restored).
- Reset mid-ROUND: assert reset_n=0 at round 30 → done=0, sdo=0; a following full "abc" run is still correct.
- done handshake: with message_load held high after a block → done stays 0 and sdo does not shift; raising message_load after done → done=0 within 3 clk.
- Empty-string block 512'h80000000…0 → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.

Source files
------------

// File: rtl/u_pcoin.sv
// SHA-256 block for the uPcoin miner: serial block load, round-per-cycle
// compression with chaining across blocks, and serial digest readout.
module u_pcoin (
    input  logic clk,
    input  logic reset_n,
    input  logic sck,
    input  logic sdi,
    output logic sdo,
    input  logic block_load,
    input  logic message_load,
    input  logic load,
    output logic done
);

    localparam logic [7:0][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // K[0] sits in the top word, so round t reads K[63 - t] == K[~t].
    localparam logic [63:0][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t            state, state_nx;
    logic [511:0]      in_sr;
    logic [2:0]        bl_sy;
    logic [1:0]        ml_sy, ld_sy;
    logic              bl_fall, ml_s, ld_s;
    logic [7:0][31:0]  hs;       // hs[7] = H0
    logic [7:0][31:0]  wv;       // wv[7] = a ... wv[0] = h
    logic [15:0][31:0] w;        // w[i] = W[t+i]
    logic [5:0]        t;
    logic              hashed;
    logic [255:0]      dout;
    logic [8:0]        rd_cnt;
    logic [31:0]       s0, s1, ch, maj, t1, t2, w_new;

    // Serial input, clocked straight off sck.
    always_ff @(posedge sck) begin
        if (block_load) in_sr <= {in_sr[510:0], sdi};
    end

    assign bl_fall = bl_sy[2] & ~bl_sy[1];
    assign ml_s    = ml_sy[1];
    assign ld_s    = ld_sy[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (bl_fall) state_nx = S_ROUND;
            S_ROUND:  if (t == 6'd63) state_nx = S_UPDATE;
            S_UPDATE: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        s1    = rotr(wv[3], 6) ^ rotr(wv[3], 11) ^ rotr(wv[3], 25);
        ch    = (wv[3] & wv[2]) ^ (~wv[3] & wv[1]);
        t1    = wv[0] + s1 + ch + K[~t] + w[0];
        s0    = rotr(wv[7], 2) ^ rotr(wv[7], 13) ^ rotr(wv[7], 22);
        maj   = (wv[7] & wv[6]) ^ (wv[7] & wv[5]) ^ (wv[6] & wv[5]);
        t2    = s0 + maj;
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    // Working set: fully rewritten at block start, so no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (bl_fall) begin
                for (int i = 0; i < 16; i++) w[i] <= in_sr[511-32*i -: 32];
                wv <= hs;
                t  <= '0;
            end
            S_ROUND: begin
                wv <= {t1 + t2, wv[7:5], wv[4] + t1, wv[3:1]};
                w  <= {w_new, w[15:1]};
                t  <= t + 6'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bl_sy  <= '0;
            ml_sy  <= '0;
            ld_sy  <= '0;
            hs     <= IV;
            hashed <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            bl_sy <= {bl_sy[1:0], block_load};
            ml_sy <= {ml_sy[0], message_load};
            ld_sy <= {ld_sy[0], load};
            if (state == S_UPDATE) begin
                for (int i = 0; i < 8; i++) hs[i] <= hs[i] + wv[i];
                hashed <= 1'b1;
            end
            if (ld_s) begin
                hs     <= IV;
                hashed <= 1'b0;
            end
            if (ml_s || ld_s) done <= 1'b0;
            else if (state == S_IDLE && !bl_fall && hashed && !done) begin
                done <= 1'b1;
                dout <= hs;
            end
        end
    end

    // Readout index counts sck falls; held at zero whenever done is low.
    always_ff @(negedge sck or negedge done) begin
        if (!done)           rd_cnt <= '0;
        else if (!rd_cnt[8]) rd_cnt <= rd_cnt + 9'd1;
    end

    assign sdo = rd_cnt[8] ? 1'b0 : dout[~rd_cnt[7:0]];

endmodule

// File: tb/tb_u_pcoin.sv
// Randomized bench for u_pcoin: messages are padded and hashed by a plain
// SHA-256 model here and compared with the serially read digest.
module tb_u_pcoin;

    logic clk = 1'b0, reset_n = 1'b1, sck = 1'b0, sdi = 1'b0;
    logic block_load = 1'b0, message_load = 1'b0, load = 1'b0;
    logic sdo, done;

    int total = 0, bad = 0;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    byte unsigned msg[$];
    logic [511:0] blks[$];

    u_pcoin dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .sdo(sdo),
        .block_load(block_load), .message_load(message_load), .load(load), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Standard padding: 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_blocks();
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] x;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        blks.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            x = '0;
            for (int j = 0; j < 64; j++) x = {x[503:0], p[b*64+j]};
            blks.push_back(x);
        end
    endtask

    function automatic logic [255:0] ref_hash();
        logic [31:0] hh[8];
        logic [31:0] W[64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 8; i++) hh[i] = IVT[i];
        foreach (blks[n]) begin
            for (int i = 0; i < 16; i++) W[i] = blks[n][511-32*i -: 32];
            for (int i = 16; i < 64; i++)
                W[i] = (rotr(W[i-2], 17) ^ rotr(W[i-2], 19) ^ (W[i-2] >> 10)) + W[i-7]
                     + (rotr(W[i-15], 7) ^ rotr(W[i-15], 18) ^ (W[i-15] >> 3)) + W[i-16];
            a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
            e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
            for (int i = 0; i < 64; i++) begin
                t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + W[i];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1;
                d = c; c = b; b = a; a = t1 + t2;
            end
            hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
            hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic sck_pulse(input logic d);
        sdi = d;
        #($urandom_range(5, 9));
        sck = 1'b1;
        #($urandom_range(2, 6));
        sck = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] b);
        block_load = 1'b1;
        #7;
        for (int i = 511; i >= 0; i--) sck_pulse(b[i]);
        #3;
        block_load = 1'b0;
        load = 1'b0;
    endtask

    task automatic read_digest(output logic [255:0] v);
        v = '0;
        for (int i = 0; i < 256; i++) begin
            #($urandom_range(2, 6));
            sck = 1'b1;
            #1;
            v = {v[254:0], sdo};
            #($urandom_range(1, 5));
            sck = 1'b0;
        end
    endtask

    task automatic run_msg(input string tag, input int gap, input logic [255:0] exp);
        logic [255:0] got;
        logic         s0;
        int           n;
        load = 1'b1;
        message_load = 1'b1;
        wait_clks(4);
        foreach (blks[i]) begin
            send_block(blks[i]);
            wait_clks(gap);
        end
        // message_load still high: no done, and stray sck edges leave sdo alone
        @(negedge clk);
        chk({tag, "_hold_done"}, done, 1'b0);
        s0 = sdo;
        for (int i = 0; i < 4; i++) sck_pulse(1'b0);
        #2;
        chk({tag, "_hold_sdo"}, sdo, s0);
        message_load = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        read_digest(got);
        chk({tag, "_digest"}, got, exp);
        message_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 1'b0);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        build_blocks();
    endtask

    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO = 256'hcf5b16a778af8380036ce59e7b0492370b249b11e8f07a51afac45037afee9d1;
    localparam logic [255:0] D_NUL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    initial begin
        int len;
        #1 reset_n = 1'b0;
        wait_clks(2);
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_sdo", sdo, 1'b0);
        @(negedge clk) reset_n = 1'b1;

        set_abc();
        run_msg("abc", 120, D_ABC);

        msg.delete();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 8; j++) msg.push_back(8'(8'h61 + i + j));
        build_blocks();
        run_msg("two_blk", 1000, D_TWO);

        set_abc();
        run_msg("abc_again", 150, D_ABC);

        // Abort a block around round 30, then confirm clean state
        set_abc();
        load = 1'b1;
        message_load = 1'b1;
        wait_clks(4);
        send_block(blks[0]);
        wait_clks(33);
        reset_n = 1'b0;
        #2;
        chk("midrst_done", done, 1'b0);
        chk("midrst_sdo", sdo, 1'b0);
        wait_clks(2);
        @(negedge clk) reset_n = 1'b1;
        message_load = 1'b0;
        wait_clks(10);
        @(negedge clk);
        chk("midrst_no_done", done, 1'b0);
        run_msg("abc_post_rst", 110, D_ABC);

        msg.delete();
        build_blocks();
        run_msg("empty", 100, D_NUL);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 150);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            build_blocks();
            run_msg($sformatf("rand%0d_len%0d", r, len), $urandom_range(100, 300), ref_hash());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
